climate_ctrl_mz: RTL and testbench
==================================

# climate_ctrl_mz

Parametrised cold-storage climate controller: samples temperature and humidity every update tick, drives fan, humidifier and heater outputs through hysteresis comparators, and raises an over-temperature alarm. It takes validated 3-byte ASCII commands from the UART receiver to set thresholds or force manual actuator states. It also formats two 16-character LCD rows for the LCD driver. It sits between the sensor/UART front-end and the LCD/LED back-end.

## Interface
- TICK_DIV, 50_000_000, clocks per update tick (≥2)
- DATA_W, 8, sensor sample width
- HYST, 2, hysteresis band (sensor units)
- ALARM_MARGIN, 5, degrees above max_temp that arm the alarm
- ALARM_TICKS, 3, consecutive armed ticks before alarm asserts
- MAX_TEMP_RST / MIN_TEMP_RST / MAX_HUM_RST / MIN_HUM_RST, 18 / 0 / 35 / 10, reset thresholds (7-bit)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- temperature  in  DATA_W  unsigned °C sample
- humidity  in  DATA_W  unsigned %RH sample
- cmd_valid  in  1  one-cycle strobe, command bytes valid
- chr_cmd, chr_val0, chr_val1  in  8 each  ASCII command, digit/flag 0, digit/flag 1
- cmd_ack  out  1  one-cycle pulse, command accepted
- cmd_err  out  1  one-cycle pulse, command rejected
- led_fan, led_hum, led_heat  out  1  actuator outputs
- alarm  out  1  over-temperature alarm
- lcd_en  out  1  one-cycle pulse, rows valid
- lcd_row1, lcd_row2  out  128  16 ASCII chars, MSB = leftmost

## Operation
- Tick counter 0..TICK_DIV-1; registered tick pulses high for one cycle when the count wraps.
- Mode register: AUTO (reset) or MANUAL.
- Commands, evaluated only on a cmd_valid cycle:
  - 'A'/'B'/'C'/'D' set max_temp/min_temp/max_hum/min_hum to 10*(val0-'0')+(val1-'0').
  - Reject with cmd_err and leave the register unchanged if either byte is outside '0'..'9'.
  - Reject if the new value would break min<max for its pair.
  - 'L': MANUAL; led_fan=(val0!='0'), led_hum=(val1!='0'), led_heat=0; always accepted.
  - 'M': AUTO; fan/hum/heat hysteresis states cleared to 0; accepted.
  - Any other chr_cmd: cmd_err.
- AUTO hysteresis, evaluated on tick, all comparisons unsigned, thresholds zero-extended:
  - fan_t on when temp>max_temp; off when temp<=max_temp-HYST (saturate at 0).
  - fan_h on when humidity>max_hum; off when humidity<=max_hum-HYST.
  - led_fan = fan_t|fan_h.
  - led_hum on when humidity<min_hum; off when humidity>=min_hum+HYST.
  - led_heat on when temp<min_temp; off when temp>=min_temp+HYST.
  - Between bands, state holds.
- MANUAL: actuators change only via 'L'/'M'; ticks do not touch them.
- Alarm, evaluated on every tick in both modes, using a saturating counter:
  - temp>max_temp+ALARM_MARGIN: increment; alarm=1 once counter reaches ALARM_TICKS.
  - temp<=max_temp: clear counter and alarm.
  - Otherwise: counter and alarm hold.
- LCD rows, built with values clamped to 99 and two decimal digits:
  - lcd_row1 = "Temp:" T1 T0 "C Fan:" F " " M, where F='1'/'0' and M='A'/'M'.
  - lcd_row2 = "Humi:" H1 H0 "% Hum:" U " " X, where U='1'/'0' and X='!' if alarm, else ' '.
- Reset values:
  - Tick counter 0, tick 0; mode AUTO; thresholds at *_RST.
  - All actuators, alarm, lcd_en, cmd_ack, cmd_err at 0; hysteresis states and alarm counter 0.
  - lcd_row1="  Cold Storage  ", lcd_row2="     Welcome    ".

## Timing
- cmd_ack/cmd_err assert the cycle after cmd_valid and last one cycle; 'L' outputs update at that same edge.
- Tick edge: actuator and alarm registers update. Next cycle: rows update and lcd_en=1 for one cycle. Rows stay stable until the next lcd_en.
- First lcd_en occurs TICK_DIV+1 cycles after reset release.
- cmd_valid on the tick cycle:
  - The tick evaluates with pre-command thresholds; new thresholds take effect from the next tick.
  - 'L'/'M' override the tick's actuator result (command wins).
- cmd_valid back-to-back: each command is processed independently.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); no lcd_en until a full TICK_DIV elapses.

## Test plan
- Fan hysteresis (TICK_DIV=8, defaults): temp 19 → led_fan=1 at tick; 17 → stays 1; 16 → 0; row1="Temp:16C Fan:0 A".
- Command "A25" → cmd_ack; temp 22 → fan 0. "A5X" → cmd_err, max_temp stays 25. "B30" while max_temp=25 → cmd_err.
- Manual mode: "L10" → led_fan=1, led_hum=0, M shown. Ticks with humidity 0 → led_hum stays 0. "M" → next tick led_hum=1.
- Alarm: temp 24 with max_temp=18 → alarm=1 on third tick, row2 ends '!'. Temp 20 → alarm holds. Temp 18 → alarm clears.
- Clamp/format: temp 7 → "Temp:07C…"; humidity 150 → "Humi:99%…".
- Reset asserted mid-tick with fan on → outputs 0 and rows at Welcome text immediately; cmd_valid coincident with tick follows the ordering rule.

Source files
------------

// File: rtl/climate_ctrl_mz.sv
// Cold-storage climate controller: tick-driven hysteresis actuators, over-temperature
// alarm, 3-byte ASCII command decode and two 16-character LCD status rows.
//
// state     | meaning
// ST_AUTO   | actuators follow the hysteresis comparators on every tick
// ST_MANUAL | actuators are held at the values forced by the last 'L' command
module climate_ctrl_mz #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int DATA_W       = 8,
  parameter int HYST         = 2,
  parameter int ALARM_MARGIN = 5,
  parameter int ALARM_TICKS  = 3,
  parameter int MAX_TEMP_RST = 18,
  parameter int MIN_TEMP_RST = 0,
  parameter int MAX_HUM_RST  = 35,
  parameter int MIN_HUM_RST  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] temperature,
  input  logic [DATA_W-1:0] humidity,
  input  logic              cmd_valid,
  input  logic [7:0]        chr_cmd,
  input  logic [7:0]        chr_val0,
  input  logic [7:0]        chr_val1,
  output logic              cmd_ack,
  output logic              cmd_err,
  output logic              led_fan,
  output logic              led_hum,
  output logic              led_heat,
  output logic              alarm,
  output logic              lcd_en,
  output logic [127:0]      lcd_row1,
  output logic [127:0]      lcd_row2
);

  localparam int TCW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW  = ((DATA_W > 7) ? DATA_W : 7) + 2;
  localparam int ACW = $clog2(ALARM_TICKS + 1);

  localparam logic [CW-1:0]  HYST_C   = CW'(HYST);
  localparam logic [CW-1:0]  MARGIN_C = CW'(ALARM_MARGIN);
  localparam logic [ACW-1:0] ATICKS_C = ACW'(ALARM_TICKS);

  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_B = 8'h42;
  localparam logic [7:0] CH_C = 8'h43;
  localparam logic [7:0] CH_D = 8'h44;
  localparam logic [7:0] CH_L = 8'h4c;
  localparam logic [7:0] CH_M = 8'h4d;
  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_9 = 8'h39;

  typedef enum logic {ST_AUTO, ST_MANUAL} mode_t;

  mode_t state_q, state_d;
  logic  auto_mode;

  logic [TCW-1:0] tick_cnt;
  logic           tick_wrap;
  logic           tick;

  logic [6:0] max_temp, min_temp, max_hum, min_hum;

  logic       digits_ok;
  logic [6:0] cmd_num;
  logic       cmd_ok;
  logic       cmd_fire;
  logic       do_l, do_m;

  logic              fan_t, fan_h;
  logic              fan_t_nx, fan_h_nx, hum_nx, heat_nx;
  logic [ACW-1:0]    alarm_cnt, alarm_cnt_nx;
  logic              alarm_nx;
  logic [DATA_W-1:0] temp_s, hum_s;

  logic [CW-1:0] temp_x, hum_x;
  logic [CW-1:0] max_t_x, min_t_x, max_h_x, min_h_x;
  logic [CW-1:0] max_t_lo, max_h_lo;

  logic [6:0]  t_clip, h_clip;
  logic [15:0] t_chars, h_chars;

  function automatic logic [15:0] two_digits(input logic [6:0] v);
    logic [6:0] tens, ones;
    tens = v / 7'd10;
    ones = v % 7'd10;
    return {CH_0 + {1'b0, tens}, CH_0 + {1'b0, ones}};
  endfunction

  // Update tick
  assign tick_wrap = (tick_cnt == TCW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick     <= tick_wrap;
      tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
    end
  end

  // Command decode
  always_comb begin
    digits_ok = (chr_val0 >= CH_0) && (chr_val0 <= CH_9) &&
                (chr_val1 >= CH_0) && (chr_val1 <= CH_9);
    cmd_num   = 7'(7'(chr_val0[3:0]) * 7'd10) + 7'(chr_val1[3:0]);
    cmd_ok    = 1'b0;
    case (chr_cmd)
      CH_A:       cmd_ok = digits_ok && (cmd_num > min_temp);
      CH_B:       cmd_ok = digits_ok && (cmd_num < max_temp);
      CH_C:       cmd_ok = digits_ok && (cmd_num > min_hum);
      CH_D:       cmd_ok = digits_ok && (cmd_num < max_hum);
      CH_L, CH_M: cmd_ok = 1'b1;
      default:    cmd_ok = 1'b0;
    endcase
    cmd_fire = cmd_valid && cmd_ok;
    do_l     = cmd_fire && (chr_cmd == CH_L);
    do_m     = cmd_fire && (chr_cmd == CH_M);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ack  <= 1'b0;
      cmd_err  <= 1'b0;
      max_temp <= 7'(MAX_TEMP_RST);
      min_temp <= 7'(MIN_TEMP_RST);
      max_hum  <= 7'(MAX_HUM_RST);
      min_hum  <= 7'(MIN_HUM_RST);
    end else begin
      cmd_ack <= cmd_valid && cmd_ok;
      cmd_err <= cmd_valid && !cmd_ok;
      if (cmd_fire) begin
        case (chr_cmd)
          CH_A:    max_temp <= cmd_num;
          CH_B:    min_temp <= cmd_num;
          CH_C:    max_hum  <= cmd_num;
          CH_D:    min_hum  <= cmd_num;
          default: ;
        endcase
      end
    end
  end

  // Mode FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_AUTO;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (do_l)      state_d = ST_MANUAL;
    else if (do_m) state_d = ST_AUTO;
  end

  always_comb begin
    auto_mode = (state_q == ST_AUTO);
  end

  // Hysteresis and alarm next-state
  always_comb begin
    temp_x   = CW'(temperature);
    hum_x    = CW'(humidity);
    max_t_x  = CW'(max_temp);
    min_t_x  = CW'(min_temp);
    max_h_x  = CW'(max_hum);
    min_h_x  = CW'(min_hum);
    max_t_lo = (max_t_x >= HYST_C) ? max_t_x - HYST_C : '0;
    max_h_lo = (max_h_x >= HYST_C) ? max_h_x - HYST_C : '0;

    fan_t_nx = fan_t;
    if (temp_x > max_t_x)        fan_t_nx = 1'b1;
    else if (temp_x <= max_t_lo) fan_t_nx = 1'b0;

    fan_h_nx = fan_h;
    if (hum_x > max_h_x)         fan_h_nx = 1'b1;
    else if (hum_x <= max_h_lo)  fan_h_nx = 1'b0;

    hum_nx = led_hum;
    if (hum_x < min_h_x)                 hum_nx = 1'b1;
    else if (hum_x >= min_h_x + HYST_C)  hum_nx = 1'b0;

    heat_nx = led_heat;
    if (temp_x < min_t_x)                heat_nx = 1'b1;
    else if (temp_x >= min_t_x + HYST_C) heat_nx = 1'b0;

    alarm_cnt_nx = alarm_cnt;
    alarm_nx     = alarm;
    if (temp_x <= max_t_x) begin
      alarm_cnt_nx = '0;
      alarm_nx     = 1'b0;
    end else if (temp_x > max_t_x + MARGIN_C) begin
      if (alarm_cnt < ATICKS_C) alarm_cnt_nx = alarm_cnt + 1'b1;
      if (alarm_cnt_nx >= ATICKS_C) alarm_nx = 1'b1;
    end
  end

  // Commands are applied after the tick result so 'L'/'M' win on a shared cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fan_t     <= 1'b0;
      fan_h     <= 1'b0;
      led_fan   <= 1'b0;
      led_hum   <= 1'b0;
      led_heat  <= 1'b0;
      alarm     <= 1'b0;
      alarm_cnt <= '0;
      temp_s    <= '0;
      hum_s     <= '0;
    end else begin
      if (tick_wrap) begin
        alarm_cnt <= alarm_cnt_nx;
        alarm     <= alarm_nx;
        temp_s    <= temperature;
        hum_s     <= humidity;
        if (auto_mode) begin
          fan_t    <= fan_t_nx;
          fan_h    <= fan_h_nx;
          led_fan  <= fan_t_nx | fan_h_nx;
          led_hum  <= hum_nx;
          led_heat <= heat_nx;
        end
      end
      if (do_l) begin
        led_fan  <= (chr_val0 != CH_0);
        led_hum  <= (chr_val1 != CH_0);
        led_heat <= 1'b0;
      end
      if (do_m) begin
        fan_t    <= 1'b0;
        fan_h    <= 1'b0;
        led_fan  <= 1'b0;
        led_hum  <= 1'b0;
        led_heat <= 1'b0;
      end
    end
  end

  // LCD formatting, one cycle after the tick edge
  always_comb begin
    t_clip  = (CW'(temp_s) > CW'(99)) ? 7'd99 : 7'(temp_s);
    h_clip  = (CW'(hum_s)  > CW'(99)) ? 7'd99 : 7'(hum_s);
    t_chars = two_digits(t_clip);
    h_chars = two_digits(h_clip);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_en   <= 1'b0;
      lcd_row1 <= "  Cold Storage  ";
      lcd_row2 <= "     Welcome    ";
    end else begin
      lcd_en <= tick;
      if (tick) begin
        lcd_row1 <= {"Temp:", t_chars, "C Fan:", (led_fan ? 8'h31 : 8'h30), 8'h20,
                     (auto_mode ? CH_A : CH_M)};
        lcd_row2 <= {"Humi:", h_chars, "% Hum:", (led_hum ? 8'h31 : 8'h30), 8'h20,
                     (alarm ? 8'h21 : 8'h20)};
      end
    end
  end

endmodule

// File: tb/tb_climate_ctrl_mz.sv
// Directed bench for climate_ctrl_mz with TICK_DIV=8 and default thresholds.
module tb_climate_ctrl_mz;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   temperature, humidity;
  logic         cmd_valid;
  logic [7:0]   chr_cmd, chr_val0, chr_val1;
  logic         cmd_ack, cmd_err;
  logic         led_fan, led_hum, led_heat, alarm, lcd_en;
  logic [127:0] lcd_row1, lcd_row2;

  int total = 0;
  int bad   = 0;

  climate_ctrl_mz #(.TICK_DIV(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .temperature(temperature), .humidity(humidity),
    .cmd_valid(cmd_valid), .chr_cmd(chr_cmd), .chr_val0(chr_val0), .chr_val1(chr_val1),
    .cmd_ack(cmd_ack), .cmd_err(cmd_err),
    .led_fan(led_fan), .led_hum(led_hum), .led_heat(led_heat), .alarm(alarm),
    .lcd_en(lcd_en), .lcd_row1(lcd_row1), .lcd_row2(lcd_row2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_lcd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lcd_en && n < 40);
    chk("lcd_en_seen", lcd_en, 1'b1);
  endtask

  task automatic first_lcd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lcd_en && n < 40);
    chk("first_lcd_latency", n, 9);
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [7:0] v0, input logic [7:0] v1,
                          input logic exp_ack);
    cmd_valid = 1'b1;
    chr_cmd   = c;
    chr_val0  = v0;
    chr_val1  = v1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_ack", cmd_ack, exp_ack);
    chk("cmd_err", cmd_err, !exp_ack);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0;
    chr_cmd = 8'h00; chr_val0 = 8'h00; chr_val1 = 8'h00;
    temperature = 8'd19; humidity = 8'd20;
    repeat (3) @(negedge clk);
    chk("rst_fan", led_fan, 1'b0);
    chk("rst_alarm", alarm, 1'b0);
    chk("rst_lcd_en", lcd_en, 1'b0);
    chk("rst_row1", lcd_row1, "  Cold Storage  ");
    chk("rst_row2", lcd_row2, "     Welcome    ");
    rst_n = 1'b1;

    // fan hysteresis with max_temp 18
    first_lcd();
    chk("fan_19", led_fan, 1'b1);
    chk("row1_19", lcd_row1, "Temp:19C Fan:1 A");
    chk("row2_19", lcd_row2, "Humi:20% Hum:0  ");
    temperature = 8'd17; wait_lcd();
    chk("fan_17_hold", led_fan, 1'b1);
    temperature = 8'd16; wait_lcd();
    chk("fan_16_off", led_fan, 1'b0);
    chk("row1_16", lcd_row1, "Temp:16C Fan:0 A");

    // threshold commands
    send_cmd("A", "2", "5", 1'b1);
    temperature = 8'd22; wait_lcd();
    chk("fan_22_max25", led_fan, 1'b0);
    send_cmd("A", "5", "X", 1'b0);
    temperature = 8'd26; wait_lcd();
    chk("fan_26_max25", led_fan, 1'b1);
    temperature = 8'd23; wait_lcd();
    chk("fan_23_max25", led_fan, 1'b0);
    send_cmd("B", "3", "0", 1'b0);
    send_cmd("Z", "1", "2", 1'b0);
    send_cmd("A", "1", "8", 1'b1);

    // alarm: armed above 23 with max_temp 18
    temperature = 8'd24; wait_lcd();
    chk("alarm_t1", alarm, 1'b0);
    wait_lcd();
    chk("alarm_t2", alarm, 1'b0);
    wait_lcd();
    chk("alarm_t3", alarm, 1'b1);
    chk("row2_alarm", lcd_row2, "Humi:20% Hum:0 !");
    temperature = 8'd20; wait_lcd();
    chk("alarm_hold", alarm, 1'b1);
    temperature = 8'd18; wait_lcd();
    chk("alarm_clear", alarm, 1'b0);
    chk("fan_18_hold", led_fan, 1'b1);

    // clamp and humidity fan
    temperature = 8'd7; humidity = 8'd150; wait_lcd();
    chk("row1_clamp", lcd_row1, "Temp:07C Fan:1 A");
    chk("row2_clamp", lcd_row2, "Humi:99% Hum:0  ");
    humidity = 8'd33; wait_lcd();
    chk("fan_h_off", led_fan, 1'b0);

    // manual mode
    send_cmd("L", "1", "0", 1'b1);
    chk("l_fan", led_fan, 1'b1);
    chk("l_hum", led_hum, 1'b0);
    humidity = 8'd0; wait_lcd();
    chk("man_hum_hold", led_hum, 1'b0);
    chk("man_row1", lcd_row1, "Temp:07C Fan:1 M");
    send_cmd("M", "0", "0", 1'b1);
    chk("m_fan_clr", led_fan, 1'b0);
    wait_lcd();
    chk("auto_hum_on", led_hum, 1'b1);
    chk("auto_row1", lcd_row1, "Temp:07C Fan:0 A");
    chk("auto_row2", lcd_row2, "Humi:00% Hum:1  ");

    // heater with min_temp 10
    send_cmd("B", "1", "0", 1'b1);
    wait_lcd();
    chk("heat_on", led_heat, 1'b1);
    temperature = 8'd11; wait_lcd();
    chk("heat_hold", led_heat, 1'b1);
    temperature = 8'd12; humidity = 8'd12; wait_lcd();
    chk("heat_off", led_heat, 1'b0);
    chk("hum_off", led_hum, 1'b0);

    // command on the tick cycle: tick uses old max_temp 18
    temperature = 8'd20;
    repeat (6) @(negedge clk);
    send_cmd("A", "3", "0", 1'b1);
    chk("tick_old_thr", led_fan, 1'b1);
    wait_lcd();
    chk("tick_old_thr_lcd", led_fan, 1'b1);
    wait_lcd();
    chk("tick_new_thr", led_fan, 1'b0);
    temperature = 8'd35;
    repeat (6) @(negedge clk);
    send_cmd("L", "0", "0", 1'b1);
    chk("tick_l_wins", led_fan, 1'b0);
    wait_lcd();
    chk("tick_l_row1", lcd_row1, "Temp:35C Fan:0 M");
    send_cmd("M", "0", "0", 1'b1);
    wait_lcd();
    chk("fan_35_max30", led_fan, 1'b1);

    // asynchronous reset mid-interval
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fan", led_fan, 1'b0);
    chk("mid_rst_lcd_en", lcd_en, 1'b0);
    chk("mid_rst_row1", lcd_row1, "  Cold Storage  ");
    chk("mid_rst_row2", lcd_row2, "     Welcome    ");
    @(negedge clk);
    rst_n = 1'b1;
    first_lcd();
    chk("post_rst_row1", lcd_row1, "Temp:35C Fan:1 A");
    chk("post_rst_alarm", alarm, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
